// File: rtl/mem_dma.sv
// mem_dma: register-programmed memory-to-memory copy engine on a native
// valid/ready CPU memory bus. Copies LEN 32-bit words from SRC to DST,
// one read followed by one write per word, at ascending addresses.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   reg_we/addr/data/q    config port: 0 SRC, 1 DST, 2 LEN, 3 CTRL
//                         CTRL = {IRQ_EN, ABORT(reads 0), DONE(w1c), START/BUSY}
//   mem_valid/ready       bus request / completion
//   mem_addr/wdata/wstrb  bus address, write data, strobes (0000 read, 1111 write)
//   mem_rdata             bus read data
//   irq                   level completion interrupt
//
// Build option: define MEM_DMA_IRQ_EN to implement CTRL.IRQ_EN and a
// registered irq = DONE & IRQ_EN. Without it irq is tied low and CTRL bit3
// reads 0.
//
// state   | meaning
// --------+---------------------------------------------------
// S_IDLE  | waiting for START
// S_READ  | read request at working src outstanding
// S_GAP_W | one idle bus cycle before the write
// S_WRITE | write request of the buffered word at working dst
// S_GAP_R | one idle bus cycle before the next read

module mem_dma #(
    parameter int LEN_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_we,
    input  logic [1:0]  reg_addr,
    input  logic [31:0] reg_data,
    output logic [31:0] reg_q,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        irq
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_GAP_W, S_WRITE, S_GAP_R
    } state_t;

    state_t state, state_nxt;

    // Reset asserts immediately, releases two clk edges after rst_n rises.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    logic [31:0]          src_reg, dst_reg, src_w, dst_w, buffer;
    logic [LEN_WIDTH-1:0] len_reg, rem;
    logic                 done, irq_en, abort_pend;

    logic ctrl_wr, start_req, abort_req, done_clr, abort_hit;
    logic load_work, step, capture, done_set, done_start_clr;

    assign ctrl_wr   = reg_we && (reg_addr == 2'd3);
    assign abort_req = ctrl_wr && reg_data[2];
    assign start_req = ctrl_wr && reg_data[0] && !reg_data[2];
    assign done_clr  = ctrl_wr && reg_data[1];
    // An abort raised during a stalled access is remembered until it resolves.
    assign abort_hit = abort_req || abort_pend;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        load_work      = 1'b0;
        step           = 1'b0;
        capture        = 1'b0;
        done_set       = 1'b0;
        done_start_clr = 1'b0;
        mem_valid      = 1'b0;
        mem_wstrb      = 4'b0000;
        mem_addr       = 32'h0;
        mem_wdata      = 32'h0;
        case (state)
            S_IDLE: begin
                if (start_req) begin
                    if (len_reg == '0) begin
                        done_set = 1'b1;
                    end else begin
                        load_work      = 1'b1;
                        done_start_clr = 1'b1;
                        state_nxt      = S_READ;
                    end
                end
            end
            S_READ: begin
                mem_valid = 1'b1;
                mem_addr  = src_w;
                if (mem_ready) begin
                    capture   = 1'b1;
                    state_nxt = abort_hit ? S_IDLE : S_GAP_W;
                end
            end
            S_GAP_W: state_nxt = abort_hit ? S_IDLE : S_WRITE;
            S_WRITE: begin
                mem_valid = 1'b1;
                mem_wstrb = 4'b1111;
                mem_addr  = dst_w;
                mem_wdata = buffer;
                if (mem_ready) begin
                    step = 1'b1;
                    if (abort_hit) begin
                        state_nxt = S_IDLE;
                    end else if (rem == LEN_WIDTH'(1)) begin
                        state_nxt = S_IDLE;
                        done_set  = 1'b1;
                    end else begin
                        state_nxt = S_GAP_R;
                    end
                end
            end
            S_GAP_R: state_nxt = abort_hit ? S_IDLE : S_READ;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            src_w      <= 32'h0;
            dst_w      <= 32'h0;
            rem        <= '0;
            buffer     <= 32'h0;
            abort_pend <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (load_work) begin
                src_w <= src_reg;
                dst_w <= dst_reg;
                rem   <= len_reg;
            end else if (step) begin
                src_w <= src_w + 32'd4;
                dst_w <= dst_w + 32'd4;
                rem   <= rem - LEN_WIDTH'(1);
            end
            if (capture) buffer <= mem_rdata;
            if (state_nxt == S_IDLE)                abort_pend <= 1'b0;
            else if (abort_req && state != S_IDLE)  abort_pend <= 1'b1;
            if (done_set)                           done <= 1'b1;
            else if (done_clr || done_start_clr)    done <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            src_reg <= 32'h0;
            dst_reg <= 32'h0;
            len_reg <= '0;
        end else if (reg_we) begin
            case (reg_addr)
                2'd0:    src_reg <= {reg_data[31:2], 2'b00};
                2'd1:    dst_reg <= {reg_data[31:2], 2'b00};
                2'd2:    len_reg <= reg_data[LEN_WIDTH-1:0];
                default: ;
            endcase
        end
    end

`ifdef MEM_DMA_IRQ_EN
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= reg_data[3];
            irq <= done && irq_en;
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        reg_q = 32'h0;
        case (reg_addr)
            2'd0:    reg_q = src_reg;
            2'd1:    reg_q = dst_reg;
            2'd2:    reg_q = 32'(len_reg);
            default: reg_q = {28'h0, irq_en, 1'b0, done, (state != S_IDLE)};
        endcase
    end

endmodule

// File: tb/tb_mem_dma.sv
module tb_mem_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_we = 1'b0;
    logic [1:0]  reg_addr = 2'd0;
    logic [31:0] reg_data = 32'h0;
    logic [31:0] reg_q;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'h0;
    logic        irq;

    mem_dma #(.LEN_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data), .reg_q(reg_q),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .irq(irq)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          cyc;
    } txn_t;

    txn_t exp_q[$];
    txn_t log_q[$];
    int n_tests = 0;
    int n_fail = 0;
    int waits = 0;
    int wait_cnt = 0;
    int valid_cycles = 0;
    int cyc = 0;
    logic        prev_valid = 1'b0, prev_ready = 1'b0;
    logic [31:0] prev_addr = 32'h0, prev_wdata = 32'h0;
    logic [3:0]  prev_wstrb = 4'h0;

    // Source memory contents are a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Expected bus sequence: per word, read src+4i then write dst+4i.
    task automatic plan(input logic [31:0] src, input logic [31:0] dst, input int len);
        txn_t t;
        for (int i = 0; i < len; i++) begin
            t.addr = src + 32'(4 * i); t.wstrb = 4'h0; t.wdata = 32'h0; t.cyc = 0;
            exp_q.push_back(t);
            t.addr = dst + 32'(4 * i); t.wstrb = 4'hF; t.wdata = mem_word(src + 32'(4 * i));
            exp_q.push_back(t);
        end
    endtask

    // Responder and compare process.
    always @(negedge clk) begin
        txn_t e, got;
        cyc++;
        if (!rst_n) begin
            mem_ready  = 1'b0;
            wait_cnt   = 0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (mem_valid) begin
                valid_cycles++;
                check("valid_after_ready", 32'(prev_ready), 32'h0);
                check("addr_align", 32'(mem_addr[1:0]), 32'h0);
                check("wstrb_legal", 32'(mem_wstrb == 4'h0 || mem_wstrb == 4'hF), 32'h1);
                if (prev_valid && !prev_ready) begin
                    check("stable_addr", mem_addr, prev_addr);
                    check("stable_wdata", mem_wdata, prev_wdata);
                    check("stable_wstrb", 32'(mem_wstrb), 32'(prev_wstrb));
                end
                if (wait_cnt >= waits) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    wait_cnt  = 0;
                    got.addr = mem_addr; got.wstrb = mem_wstrb; got.wdata = mem_wdata; got.cyc = cyc;
                    log_q.push_back(got);
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_txn actual addr=%h wstrb=%h required none", mem_addr, mem_wstrb);
                    end else begin
                        e = exp_q.pop_front();
                        check("txn_addr", mem_addr, e.addr);
                        check("txn_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
                        if (e.wstrb == 4'hF) check("txn_wdata", mem_wdata, e.wdata);
                    end
                end else begin
                    mem_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                wait_cnt  = 0;
            end
            prev_valid = mem_valid;
            prev_ready = mem_ready;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
            prev_wstrb = mem_wstrb;
        end
    end

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_we = 1'b1; reg_addr = a; reg_data = d;
        @(negedge clk);
        reg_we = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        reg_addr = a;
        #1;
        d = reg_q;
    endtask

    task automatic wait_idle(input int max_cyc);
        logic [31:0] c;
        bit idle = 0;
        for (int i = 0; i < max_cyc && !idle; i++) begin
            reg_read(2'd3, c);
            if (c[0] == 1'b0) idle = 1;
            else @(negedge clk);
        end
        if (!idle) begin
            n_tests++; n_fail++;
            $display("FAIL wait_idle_timeout actual busy required idle");
        end
    endtask

    task automatic run(input logic [31:0] src, input logic [31:0] dst, input int len,
                       input int w, input logic [31:0] ctrl);
        logic [31:0] c;
        waits = w;
        plan(src, dst, len);
        reg_write(2'd0, src);
        reg_write(2'd1, dst);
        reg_write(2'd2, 32'(len));
        reg_write(2'd3, ctrl);
        reg_read(2'd3, c);
        check("busy_after_start", 32'(c[0]), 32'h1);
        check("done_cleared_on_start", 32'(c[1]), 32'h0);
        wait_idle(3000);
        reg_read(2'd3, c);
        check("done_after_copy", 32'(c[1]), 32'h1);
        check("exp_queue_empty", 32'(exp_q.size()), 32'h0);
        reg_read(2'd0, c); check("src_unchanged", c, src);
        reg_read(2'd1, c); check("dst_unchanged", c, dst);
        reg_read(2'd2, c); check("len_unchanged", c, 32'(len));
    endtask

    initial begin
        logic [31:0] c;
        int vc;
        bit found;

        // Reset state
        @(negedge clk);
        check("rst_valid", 32'(mem_valid), 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_wstrb", 32'(mem_wstrb), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        for (int a = 0; a < 4; a++) begin
            reg_read(2'(a), c);
            check("rst_reg", c, 32'h0);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic copy, zero wait
        log_q.delete();
        run(32'h1000, 32'h2000, 3, 0, 32'h1);
        check("log_size", 32'(log_q.size()), 32'd6);
        check("lit_rd0", log_q[0].addr, 32'h0000_1000);
        check("lit_wr0", log_q[1].addr, 32'h0000_2000);
        check("lit_wd0", log_q[1].wdata, 32'h1000_EFFF);
        check("lit_rd2", log_q[4].addr, 32'h0000_1008);
        check("lit_wr2", log_q[5].addr, 32'h0000_2008);
        check("lit_wd2", log_q[5].wdata, 32'h1008_EFF7);
        check("word_period", 32'(log_q[2].cyc - log_q[0].cyc), 32'd4);
        check("rd_to_wr", 32'(log_q[1].cyc - log_q[0].cyc), 32'd2);

        // Wait states
        run(32'h3000, 32'h4000, 2, 5, 32'h1);

        // LEN = 0
        vc = valid_cycles;
        reg_write(2'd2, 32'h0);
        reg_write(2'd3, 32'h1);
        reg_read(2'd3, c);
        check("len0_done", 32'(c[1]), 32'h1);
        check("len0_busy", 32'(c[0]), 32'h0);
        repeat (3) @(negedge clk);
        check("len0_no_bus", 32'(valid_cycles), 32'(vc));
        reg_write(2'd3, 32'h2);
        reg_read(2'd3, c);
        check("done_w1c", 32'(c[1]), 32'h0);

        // Address wrap
        log_q.delete();
        run(32'hFFFF_FFFC, 32'h5000, 2, 1, 32'h1);
        check("wrap_rd1", log_q[2].addr, 32'h0000_0000);

        // Register writes and START while busy
        waits = 3;
        plan(32'h6000, 32'h7000, 2);
        reg_write(2'd0, 32'h6000);
        reg_write(2'd1, 32'h7000);
        reg_write(2'd2, 32'h2);
        reg_write(2'd3, 32'h1);
        reg_write(2'd0, 32'h9003);
        reg_write(2'd3, 32'h1);
        wait_idle(3000);
        check("busy_write_exp_empty", 32'(exp_q.size()), 32'h0);
        reg_read(2'd0, c);
        check("src_written_busy", c, 32'h9000);
        reg_read(2'd3, c);
        check("busy_write_done", 32'(c[1]), 32'h1);

        // Abort during second read wait
        log_q.delete();
        waits = 5;
        plan(32'hA000, 32'hB000, 4);
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        reg_write(2'd0, 32'hA000);
        reg_write(2'd1, 32'hB000);
        reg_write(2'd2, 32'h4);
        reg_write(2'd3, 32'h1);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (mem_valid && mem_wstrb == 4'h0 && mem_addr == 32'hA004) found = 1;
        end
        check("abort_found_read", 32'(found), 32'h1);
        reg_write(2'd3, 32'h5);
        wait_idle(200);
        repeat (3) @(negedge clk);
        reg_read(2'd3, c);
        check("abort_done0", 32'(c[1]), 32'h0);
        check("abort_exp_empty", 32'(exp_q.size()), 32'h0);
        check("abort_txn_count", 32'(log_q.size()), 32'd3);

        // Interrupt
`ifdef MEM_DMA_IRQ_EN
        run(32'hC000, 32'hD000, 1, 0, 32'h9);
        check("irq_low_at_done", 32'(irq), 32'h0);
        @(negedge clk);
        check("irq_set", 32'(irq), 32'h1);
        reg_read(2'd3, c);
        check("irq_en_read", 32'(c[3]), 32'h1);
        reg_write(2'd3, 32'h2);
        check("irq_hold_one", 32'(irq), 32'h1);
        @(negedge clk);
        check("irq_cleared", 32'(irq), 32'h0);
`else
        run(32'hC000, 32'hD000, 1, 0, 32'h9);
        @(negedge clk);
        check("irq_tied0", 32'(irq), 32'h0);
        reg_read(2'd3, c);
        check("irq_en_absent", 32'(c[3]), 32'h0);
`endif

        // Reset mid-transfer
        waits = 4;
        plan(32'hE000, 32'hF000, 3);
        reg_write(2'd0, 32'hE000);
        reg_write(2'd1, 32'hF000);
        reg_write(2'd2, 32'h3);
        reg_write(2'd3, 32'h1);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (mem_valid) found = 1;
        end
        check("rst_mid_found_valid", 32'(found), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(mem_valid), 32'h0);
        check("rst_mid_addr", mem_addr, 32'h0);
        check("rst_mid_wstrb", 32'(mem_wstrb), 32'h0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        vc = valid_cycles;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_mid_no_bus", 32'(valid_cycles), 32'(vc));
        reg_read(2'd0, c); check("rst_mid_src", c, 32'h0);
        reg_read(2'd3, c); check("rst_mid_ctrl", c, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
